// File: rtl/mem_pkg.sv
// Shared definitions for the single-port-memory FIFO: default widths and
// the per-cycle memory grant encoding.
package mem_pkg;

   localparam int unsigned MEM_DATA_WIDTH = 2;
   localparam int unsigned MEM_ADDR_WIDTH = 2;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WR   = 2'd1,
      GNT_RD   = 2'd2
   } grant_e;

endpackage : mem_pkg

// File: rtl/mem_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port memory with one-cycle read latency;
// one access per cycle, round-robin between write and read.
module mem_fifo_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  mem_wr,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  last_wr_q, last_wr_d;

   logic   rd_elig;
   logic   wr_go;
   logic   rd_go;
   grant_e grant;

   // Arbitration: a read is only issued when the output register is free,
   // so the memory dout can always be captured the cycle after mem_re.
   always_comb begin
      rd_elig  = (count_q != '0) && !rd_pend_q && !out_valid_q;
      in_ready = (count_q != CNT_W'(DEPTH)) && !(rd_elig && last_wr_q) && !rst;
      wr_go    = in_valid && in_ready;
      rd_go    = rd_elig && !wr_go && !rst;

      if (wr_go) begin
         grant = GNT_WR;
      end else if (rd_go) begin
         grant = GNT_RD;
      end else begin
         grant = GNT_NONE;
      end

      mem_wr   = wr_go;
      mem_re   = rd_go;
      mem_addr = wr_go ? wptr_q : rptr_q;
      mem_din  = in_data;
   end

   // Next-state for pointers, occupancy and the output register.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      rd_pend_d   = rd_pend_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      last_wr_d   = last_wr_q;

      if (rd_pend_q) begin
         out_data_d  = mem_dout;
         out_valid_d = 1'b1;
         rd_pend_d   = 1'b0;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (grant)
         GNT_WR: begin
            wptr_d    = wptr_q + ADDR_WIDTH'(1);
            count_d   = count_q + CNT_W'(1);
            last_wr_d = 1'b1;
         end
         GNT_RD: begin
            rptr_d    = rptr_q + ADDR_WIDTH'(1);
            count_d   = count_q - CNT_W'(1);
            rd_pend_d = 1'b1;
            last_wr_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rd_pend_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         last_wr_q   <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         rd_pend_q   <= rd_pend_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         last_wr_q   <= last_wr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule : mem_fifo_ctrl
